banked_mem: RTL



---
 rtl/banked_mem_if.sv | 36 +++
 rtl/banked_mem.sv | 84 ++++++++
 2 files changed

// File: rtl/banked_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : banked_mem_if
// Description : Request/response bus between the cache controller and banked_mem.
//               The err signal exists only when BANKED_MEM_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface banked_mem_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        stall;
    logic [3:0]  busy;
`ifdef BANKED_MEM_ERR_EN
    logic        err;
`endif

    modport master (
        output Addr, DataIn, Rd, Wr,
`ifdef BANKED_MEM_ERR_EN
        input  err,
`endif
        input  DataOut, stall, busy
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr,
`ifdef BANKED_MEM_ERR_EN
        output err,
`endif
        output DataOut, stall, busy
    );
endinterface
`default_nettype wire

// File: rtl/banked_mem.sv
`default_nettype none
// ============================================================================
// Module      : banked_mem
// Description : Four-bank word-interleaved memory with per-bank busy window and
//               two-cycle read latency. Optional macro BANKED_MEM_ERR_EN adds err.
// Revision    : 1.0 - initial release
// ============================================================================
module banked_mem #(
    parameter int BANK_WORDS  = 8192,
    parameter int BUSY_CYCLES = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    banked_mem_if.slave   bus
);
    localparam int         ROW_W     = $clog2(BANK_WORDS);
    localparam int         IDX_W     = ROW_W + 2;
    localparam logic [1:0] BUSY_LOAD = 2'(BUSY_CYCLES - 1);

    // Bank bits sit just above Addr[0], so the flat word index interleaves banks.
    logic [15:0]      mem_q [4*BANK_WORDS];
    logic [1:0]       w_bank;
    logic [IDX_W-1:0] w_idx;
    logic             w_valid;
    logic             w_accept;
    logic [3:0]       w_busy;
    logic [1:0]       cnt_q [4];
    logic [1:0]       cnt_d [4];
    logic             rd_vld_q;
    logic [15:0]      rd_data_q;
    logic [15:0]      dout_q;

    assign w_bank = bus.Addr[2:1];
    assign w_idx  = bus.Addr[IDX_W:1];

`ifdef BANKED_MEM_ERR_EN
    assign w_valid = (bus.Rd ^ bus.Wr) & ~bus.Addr[0];
    assign bus.err = rst_n & ((bus.Rd & bus.Wr) | ((bus.Rd | bus.Wr) & bus.Addr[0]));
`else
    assign w_valid = bus.Rd ^ bus.Wr;
`endif

    assign bus.stall = w_valid & w_busy[w_bank];
    // rst_n gates accept so the unreset array cannot be written during reset.
    assign w_accept  = w_valid & ~w_busy[w_bank] & rst_n;

    for (genvar i = 0; i < 4; i++) begin : g_bank
        assign w_busy[i] = (cnt_q[i] != 2'd0);
        assign cnt_d[i]  = (w_accept && (w_bank == 2'(i))) ? BUSY_LOAD :
                           w_busy[i]                        ? cnt_q[i] - 2'd1 :
                                                              cnt_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && bus.Wr) begin
            mem_q[w_idx] <= bus.DataIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= 16'h0000;
            dout_q    <= 16'h0000;
        end else begin
            rd_vld_q  <= w_accept & bus.Rd;
            rd_data_q <= mem_q[w_idx];
            dout_q    <= rd_vld_q ? rd_data_q : 16'h0000;
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.busy    = w_busy;

endmodule
`default_nettype wire
